// File: rtl/waveform_meas_if.sv
// Result handshake between the period/duty measurement stage and its consumer.
// The master holds the result steady while res_valid is high; the slave acks it with res_ack.
interface waveform_meas_if #(
    parameter int CNT_W = 8
);
    logic             res_valid;
    logic             res_ack;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic             sat;

    modport master (
        output res_valid,
        output high_len,
        output low_len,
        output sat,
        input  res_ack
    );

    modport slave (
        input  res_valid,
        input  high_len,
        input  low_len,
        input  sat,
        output res_ack
    );
endinterface

// File: rtl/waveform_meas.sv
// Measures high/low run lengths of sig_in and publishes one {high_len, low_len} result per complete period.
// Latency: the result is registered on the edge that samples the rising level ending the period.
// Backpressure: a held, unacked result is kept; newer results are dropped and the sticky overrun flag is set.
module waveform_meas #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sig_in,
    waveform_meas_if.master   res,
    output logic [CNT_W-1:0]  pulse_cnt,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        HIGH,
        LOW
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] hi_nxt;
    logic [CNT_W-1:0] lo_cnt;
    logic [CNT_W-1:0] lo_nxt;
    logic             publish;
    logic             load;

    logic             res_vld_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] low_q;
    logic             sat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            state  <= state_nxt;
            hi_cnt <= hi_nxt;
            lo_cnt <= lo_nxt;
        end
    end

    // IDLE waits for a low level so a pulse already in progress at reset release is never measured.
    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_cnt;
        lo_nxt    = lo_cnt;
        publish   = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (!sig_in) state_nxt = SYNC;
                end
                SYNC: begin
                    if (sig_in) begin
                        state_nxt = HIGH;
                        hi_nxt    = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (sig_in) begin
                        if (hi_cnt != CNT_MAX) hi_nxt = hi_cnt + CNT_ONE;
                    end else begin
                        state_nxt = LOW;
                        lo_nxt    = CNT_ONE;
                    end
                end
                LOW: begin
                    if (!sig_in) begin
                        if (lo_cnt != CNT_MAX) lo_nxt = lo_cnt + CNT_ONE;
                    end else begin
                        publish   = 1'b1;
                        state_nxt = HIGH;
                        hi_nxt    = CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // An ack in the same cycle frees the slot, so a back-to-back publish is loaded rather than dropped.
    assign load = publish && (!res_vld_q || res.res_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_vld_q <= 1'b0;
            high_q    <= '0;
            low_q     <= '0;
            sat_q     <= 1'b0;
            pulse_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                res_vld_q <= 1'b1;
                high_q    <= hi_cnt;
                low_q     <= lo_cnt;
                sat_q     <= (hi_cnt == CNT_MAX) || (lo_cnt == CNT_MAX);
            end else if (res.res_ack) begin
                res_vld_q <= 1'b0;
            end
            if (publish) pulse_cnt <= pulse_cnt + CNT_ONE;
            if (publish && !load) overrun <= 1'b1;
        end
    end

    assign res.res_valid = res_vld_q;
    assign res.high_len  = high_q;
    assign res.low_len   = low_q;
    assign res.sat       = sat_q;

endmodule

// File: tb/tb_waveform_meas.sv
// Directed, table-driven bench for waveform_meas at CNT_W=4 (small width exposes saturation and wrap).
module tb_waveform_meas;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         sig_in;
    logic [W-1:0] pulse_cnt;
    logic         overrun;

    waveform_meas_if #(.CNT_W(W)) res_if ();

    waveform_meas #(.CNT_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sig_in    (sig_in),
        .res       (res_if.master),
        .pulse_cnt (pulse_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         s;
        logic         ack;
        logic         vld;
        logic [W-1:0] hl;
        logic [W-1:0] ll;
        logic         sat;
        logic [W-1:0] pc;
        logic         ov;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void add(input logic en, input logic s, input logic ack,
                                input logic vld, input int hl, input int ll,
                                input logic sat, input int pc, input logic ov);
        vec_t v;
        v.en  = en;
        v.s   = s;
        v.ack = ack;
        v.vld = vld;
        v.hl  = W'(hl);
        v.ll  = W'(ll);
        v.sat = sat;
        v.pc  = W'(pc);
        v.ov  = ov;
        tbl.push_back(v);
    endfunction

    // Data fields are only meaningful while a result is held, so they are masked when none is expected.
    task automatic run_tbl(input string name);
        logic [14:0] got;
        logic [14:0] exp;
        for (int i = 0; i < tbl.size(); i++) begin
            enable         = tbl[i].en;
            sig_in         = tbl[i].s;
            res_if.res_ack = tbl[i].ack;
            @(posedge clk);
            #1;
            if (tbl[i].vld) begin
                got = {res_if.res_valid, res_if.high_len, res_if.low_len, res_if.sat, pulse_cnt, overrun};
                exp = {tbl[i].vld, tbl[i].hl, tbl[i].ll, tbl[i].sat, tbl[i].pc, tbl[i].ov};
            end else begin
                got = {res_if.res_valid, 9'd0, pulse_cnt, overrun};
                exp = {tbl[i].vld, 9'd0, tbl[i].pc, tbl[i].ov};
            end
            n_chk++;
            if (got === exp) n_pass++;
            else $display("FAIL %s row %0d: got {vld,hl,ll,sat,pc,ov}=%h required %h", name, i, got, exp);
        end
        tbl.delete();
    endtask

    task automatic check_zero(input string name);
        logic [14:0] got;
        got = {res_if.res_valid, res_if.high_len, res_if.low_len, res_if.sat, pulse_cnt, overrun};
        n_chk++;
        if (got === 15'd0) n_pass++;
        else $display("FAIL %s: got outputs %h required 0", name, got);
    endtask

    task automatic do_reset(input logic s);
        enable         = 1'b1;
        sig_in         = s;
        res_if.res_ack = 1'b0;
        reset          = 1'b0;
        #2;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        sig_in         = 1'b0;
        res_if.res_ack = 1'b0;
        #3;

        // Basic: 0,0 then 1,1,1,0,0 repeated, consumer acking.
        do_reset(1'b0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 3, 2, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 3, 2, 0, 2, 0);
        // Hold, then ack coinciding with a publish: new result loads, no overrun.
        add(1, 1, 0, 1, 3, 2, 0, 2, 0);
        add(1, 0, 0, 1, 3, 2, 0, 2, 0);
        add(1, 1, 1, 1, 2, 1, 0, 3, 0);
        add(1, 1, 1, 0, 0, 0, 0, 3, 0);
        run_tbl("basic");

        // Partial pulse at reset release is discarded.
        do_reset(1'b1);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 2, 1, 0, 1, 0);
        run_tbl("partial");

        // Handshake and overrun with no ack, pattern 1,0.
        do_reset(1'b0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 1, 1, 1, 0, 2, 1);
        add(1, 1, 0, 1, 1, 1, 0, 2, 1);
        add(1, 0, 0, 1, 1, 1, 0, 2, 1);
        add(1, 0, 0, 1, 1, 1, 0, 2, 1);
        add(1, 1, 1, 1, 2, 2, 0, 3, 1);
        add(1, 1, 1, 0, 0, 0, 0, 3, 1);
        add(1, 0, 1, 0, 0, 0, 0, 3, 1);
        run_tbl("handshake");

        // Saturation: 20 high, 2 low, then 16 more minimum periods to wrap pulse_cnt.
        do_reset(1'b0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 15, 2, 1, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            add(1, 0, 1, 0, 0, 0, 0, k % 16, 0);
            add(1, 1, 1, 1, 1, 1, 0, (k + 1) % 16, 0);
        end
        run_tbl("sat_wrap");

        // Enable gating: disabled cycles neither count nor see the level change.
        do_reset(1'b0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 2, 0, 1, 0);
        add(0, 0, 0, 1, 1, 2, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_tbl("enable");

        // Mid-operation asynchronous reset while a result is held and overrun is set.
        do_reset(1'b0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 1, 0);
        add(1, 0, 0, 1, 1, 1, 0, 1, 0);
        add(1, 1, 0, 1, 1, 1, 0, 2, 1);
        run_tbl("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        sig_in = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 1, 0, 1, 0);
        run_tbl("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
